// File: rtl/screen_reader_pkg.sv
// Shared constants and FSM state encoding for the Hack screen reader.
`ifndef SCREEN_READER_PKG_SV
`define SCREEN_READER_PKG_SV
package screen_reader_pkg;

  localparam int unsigned HACK_W            = 16;
  localparam int unsigned DEF_WORDS_PER_ROW = 32;
  localparam int unsigned DEF_ROWS          = 256;
  localparam int unsigned DEF_ADDR_W        = 13;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage
`endif

// File: rtl/screen_reader_if.sv
// Screen RAM read port plus pixel stream handshake.
interface screen_reader_if #(
  parameter int unsigned ADDR_W = screen_reader_pkg::DEF_ADDR_W
) ();
  logic                                  mem_rd;
  logic [ADDR_W-1:0]                     mem_addr;
  logic [screen_reader_pkg::HACK_W-1:0]  mem_data;
  logic                                  pix_valid;
  logic                                  pix_ready;
  logic                                  pix;
  logic                                  pix_sof;
  logic                                  pix_eol;

  modport master (
    output mem_rd, mem_addr, pix_valid, pix, pix_sof, pix_eol,
    input  mem_data, pix_ready
  );

  modport slave (
    input  mem_rd, mem_addr, pix_valid, pix, pix_sof, pix_eol,
    output mem_data, pix_ready
  );
endinterface

// File: rtl/screen_reader_word_serializer.sv
// Shift/hold register pair: serialises one 16-bit word LSB first and swaps
// in the prefetched word on the bit-15 transfer without a bubble.
module screen_reader_word_serializer
  import screen_reader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              hold_we_i,
  input  logic              xfer_i,
  input  logic [HACK_W-1:0] data_i,
  output logic              pix_o,
  output logic [3:0]        bit_idx_o,
  output logic              last_bit_o
);

  logic [HACK_W-1:0] shift_q, shift_d;
  logic [HACK_W-1:0] hold_q, hold_d;
  logic [3:0]        bit_q, bit_d;
  logic              hold_full_q, hold_full_d;

  // Next-state: initial load, per-transfer advance, reload from hold, prefetch capture
  always_comb begin
    shift_d     = shift_q;
    hold_d      = hold_q;
    bit_d       = bit_q;
    hold_full_d = hold_full_q;
    if (load_i) begin
      shift_d     = data_i;
      bit_d       = '0;
      hold_full_d = 1'b0;
    end else if (xfer_i) begin
      if (bit_q == 4'd15) begin
        bit_d = '0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
        end
      end else begin
        bit_d = bit_q + 4'd1;
      end
    end
    // Prefetch capture lands two cycles into a word, never on the reload edge
    if (hold_we_i) begin
      hold_d      = data_i;
      hold_full_d = 1'b1;
    end
  end

  // Register the serializer state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      hold_q      <= '0;
      bit_q       <= '0;
      hold_full_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      bit_q       <= bit_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign pix_o      = shift_q[bit_q];
  assign bit_idx_o  = bit_q;
  assign last_bit_o = (bit_q == 4'd15);

endmodule

// File: rtl/screen_reader.sv
// Scans the Hack screen RAM and streams it out one pixel per cycle,
// prefetching the next word while the current one shifts out.
module screen_reader
  import screen_reader_pkg::*;
#(
  parameter int unsigned WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int unsigned ROWS          = DEF_ROWS,
  parameter int unsigned ADDR_W        = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  screen_reader_if.master  bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_ROW * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(WORDS_PER_ROW - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              first_q, first_d;
  logic              pend_q, pend_d;

  logic              rd, valid, ld, xfer, has_next;
  logic [ADDR_W-1:0] addr;
  logic              ser_pix, last_bit;
  logic [3:0]        bit_idx;

  assign has_next = (word_q != LAST_WORD);

  // FSM next-state, address counters and read strobes
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    col_d   = col_q;
    first_d = 1'b0;
    pend_d  = 1'b0;
    rd      = 1'b0;
    addr    = '0;
    ld      = 1'b0;
    xfer    = 1'b0;
    valid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          word_d  = '0;
          col_d   = '0;
        end
      end
      ST_FETCH: begin
        rd      = 1'b1;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        ld      = 1'b1;
        first_d = 1'b1;
        state_d = ST_STREAM;
      end
      ST_STREAM: begin
        valid = 1'b1;
        xfer  = bus.pix_ready;
        if (first_q && has_next) begin
          rd     = 1'b1;
          addr   = word_q + ADDR_W'(1);
          pend_d = 1'b1;
        end
        if (xfer && last_bit) begin
          if (has_next) begin
            word_d  = word_q + ADDR_W'(1);
            col_d   = (col_q == LAST_COL) ? '0 : col_q + ADDR_W'(1);
            first_d = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      col_q   <= '0;
      first_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      col_q   <= col_d;
      first_q <= first_d;
      pend_q  <= pend_d;
    end
  end

  screen_reader_word_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ld),
    .hold_we_i  (pend_q),
    .xfer_i     (xfer),
    .data_i     (bus.mem_data),
    .pix_o      (ser_pix),
    .bit_idx_o  (bit_idx),
    .last_bit_o (last_bit)
  );

  assign bus.mem_rd    = rd;
  assign bus.mem_addr  = addr;
  assign bus.pix_valid = valid;
  assign bus.pix       = valid & ser_pix;
  assign bus.pix_sof   = valid && (word_q == '0) && (bit_idx == 4'd0);
  assign bus.pix_eol   = valid && last_bit && (col_q == LAST_COL);
  assign busy          = (state_q != ST_IDLE);
  assign frame_done    = (state_q == ST_DONE);

endmodule
